// File: rtl/mlkem_poly_acc.sv
// mlkem_poly_acc
// Polynomial accumulator for the ML-KEM datapath. One polynomial of N
// coefficients is held in an internal synchronous RAM, LANES coefficients
// per word. A data pass streams DEPTH input words and either loads, adds or
// subtracts (mod-Q offset) them lane-wise into the stored polynomial. An
// optional reduce pass then brings every coefficient into [0,Q) with a
// Barrett reduction.
//
// Ports:
//   clk       clock
//   rst       synchronous, active-low reset
//   start     begin a pass (sampled only in IDLE)
//   mode      00 load, 01 add, 10 sub, 11 reduce-only (latched on start)
//   reduce    run a reduce pass after the data pass (latched on start)
//   in_valid  input word valid
//   in_ready  block accepts the input word (high throughout ACCUM)
//   in_data   LANES coefficients, lane j at [j*WIDTH +: WIDTH], each in [0,Q)
//   rd_addr   external read address
//   rd_data   RAM[rd_addr], one cycle latency, meaningful only when idle
//   busy      high in every state other than IDLE
//   done      one-cycle pulse at the end of the operation
//   ovf       sticky, set when an add/sub lane result does not fit WIDTH bits
module mlkem_poly_acc #(
    parameter int N     = 256,
    parameter int LANES = 1,
    parameter int WIDTH = 16,
    parameter int Q     = 3329,
    localparam int DEPTH = N / LANES,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic                   reduce,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [AW-1:0]          rd_addr,
    output logic [LANES*WIDTH-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf
);
    localparam int DW = LANES * WIDTH;
    localparam int RW = LANES * (WIDTH + 1);
    // Product a*MU needs WIDTH+15 bits; one spare keeps the subtraction clean.
    localparam int PW    = WIDTH + 16;
    localparam int SHIFT = 26;
    localparam logic [PW-1:0]    MU   = PW'(20159);
    localparam logic [PW-1:0]    QP   = PW'(Q);
    localparam logic [WIDTH:0]   QW1  = (WIDTH + 1)'(Q);
    localparam logic [WIDTH-1:0] QW   = WIDTH'(Q);
    localparam logic [AW-1:0]    LAST = AW'(DEPTH - 1);

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_SUB  = 2'b10;
    localparam logic [1:0] MODE_RED  = 2'b11;

    typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, RED, DONE} state_t;

    state_t          state, next_state;
    // Word counter: accept index in ACCUM, issue index in RED. The extra MSB
    // marks that all DEPTH addresses of the reduce pass have been issued.
    logic [AW:0]     cnt;
    logic [1:0]      mode_q;
    logic            red_en;
    logic            accept, issue;

    // Accumulate write stage: the word accepted last cycle meets its RAM data.
    logic            wr_pend;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   in_q;
    logic [DW-1:0]   acc_wdata;
    logic [LANES-1:0] lane_ovf;

    // Reduce pipeline: v1 = RAM data valid, v2 = multiply stage, v3 = corrected.
    logic            v1, v2, v3;
    logic [AW-1:0]   a1, a2, a3;
    logic [RW-1:0]   mul_d, mul_q;
    logic [DW-1:0]   red_d, red_data;

    logic [DW-1:0]   mem [DEPTH];
    logic            we;
    logic [AW-1:0]   waddr, raddr;
    logic [DW-1:0]   wdata;

    assign accept = in_valid && (state == ACCUM);
    assign issue  = (state == RED) && !cnt[AW];

    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = (mode == MODE_RED) ? RED : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && cnt[AW-1:0] == LAST) next_state = FLUSH;
            end
            FLUSH:   next_state = red_en ? RED : DONE;
            RED:     if (v3 && a3 == LAST) next_state = DONE;
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_pend <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= next_state;
            wr_pend <= accept;
            v1      <= issue;
            v2      <= v1;
            v3      <= v2;
            unique case (state)
                ACCUM:   if (accept) cnt <= cnt + (AW + 1)'(1);
                RED:     if (issue) cnt <= cnt + (AW + 1)'(1);
                default: cnt <= '0;
            endcase
            if (state == IDLE && start && mode == MODE_LOAD)
                ovf <= 1'b0;
            else if (wr_pend && mode_q != MODE_LOAD && |lane_ovf)
                ovf <= 1'b1;
        end
    end

    // Datapath registers carry no reset: their contents are qualified by the
    // valid flags above.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            mode_q <= mode;
            red_en <= reduce;
        end
        if (accept) begin
            in_q    <= in_data;
            wr_addr <= cnt[AW-1:0];
        end
        a1       <= cnt[AW-1:0];
        a2       <= a1;
        a3       <= a2;
        mul_q    <= mul_d;
        red_data <= red_d;
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [WIDTH-1:0] s, x;
        logic [WIDTH:0]   sum;
        logic [PW-1:0]    prod, qq, t;
        logic [WIDTH:0]   t1, r;

        assign s = rd_data[j*WIDTH +: WIDTH];
        assign x = in_q[j*WIDTH +: WIDTH];

        // Subtraction adds Q-in so the result stays non-negative for in < Q.
        always_comb begin
            sum = {1'b0, x};
            unique case (mode_q)
                MODE_ADD: sum = {1'b0, s} + {1'b0, x};
                MODE_SUB: sum = {1'b0, s} + {1'b0, QW - x};
                default:  sum = {1'b0, x};
            endcase
        end
        assign acc_wdata[j*WIDTH +: WIDTH] = sum[WIDTH-1:0];
        assign lane_ovf[j]                 = sum[WIDTH];

        // Barrett: the quotient estimate never exceeds the true quotient and
        // is short by at most one, so t lands in [0,2Q).
        assign prod = PW'(s) * MU;
        assign qq   = prod >> SHIFT;
        assign t    = PW'(s) - qq * QP;
        assign mul_d[j*(WIDTH+1) +: WIDTH+1] = t[WIDTH:0];

        assign t1 = mul_q[j*(WIDTH+1) +: WIDTH+1];
        assign r  = (t1 >= QW1) ? t1 - QW1 : t1;
        assign red_d[j*WIDTH +: WIDTH] = r[WIDTH-1:0];
    end

    // The accumulate write and the reduce write-back never overlap in time.
    assign we    = wr_pend || v3;
    assign waddr = wr_pend ? wr_addr : a3;
    assign wdata = wr_pend ? acc_wdata : red_data;
    assign raddr = (state == IDLE) ? rd_addr : cnt[AW-1:0];

    // NOTE: the RAM array has no reset; its contents survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Single read port shared by the FSM and the external reader.
    always_ff @(posedge clk) begin
        if (!rst) rd_data <= '0;
        else      rd_data <= mem[raddr];
    end
endmodule
